control_pipeline: RTL

- Consumer end of the main decoder's control bundle (Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp).
- Carries the bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles, flushes wrong-path work on a taken branch, and generates EX-stage forwarding selects.
- Sits between the decoder/register file in ID and the datapath of the EX, MEM and WB stages.

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/forwarding_unit.sv | 43 ++++
 rtl/control_pipeline.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the control pipeline: the decoder's control
// bundle, the bubble value, ALUOp encodings and forwarding-select encodings.
package ctrl_pkg;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       memto_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    // An instruction reads rs2 unless it is an immediate ALU op; stores and
    // branches read it even though they set alu_src or compare directly.
    function automatic logic uses_rs2(input ctrl_t c);
        return !c.alu_src || c.mem_write || c.branch;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding selects, purely combinational from the
// MEM and WB stage registers. The younger (MEM) producer wins.
module forwarding_unit
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b
);

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    function automatic fwd_t select(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_rd
    );
        if (m_we && (m_rd != '0) && (m_rd == rs)) begin
            return FWD_MEM;
        end
        if (w_we && (w_rd != '0) && (w_rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    fwd_t sel_a;
    fwd_t sel_b;

    assign sel_a     = select(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    assign sel_b     = select(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    assign forward_a = sel_a;
    assign forward_b = sel_b;

endmodule

// File: rtl/control_pipeline.sv
// Carries the decoder's control bundle through ID/EX, EX/MEM and MEM/WB,
// and generates load-use stalls, branch flushes and EX forwarding selects.
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_memto_reg,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic [1:0]            id_alu_op,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  ex_alu_src,
    output logic [1:0]            ex_alu_op,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  mem_branch,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_reg_write,
    output logic                  wb_memto_reg,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } ex_stage_t;

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [REG_ADDR_W-1:0] rd;
    } late_stage_t;

    ex_stage_t   ex_q,  ex_d;
    late_stage_t mem_q, mem_d;
    late_stage_t wb_q,  wb_d;

    ctrl_t id_ctrl;
    logic  load_use;
    logic  stall;
    logic  flush;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        id_ctrl           = BUBBLE;
        id_ctrl.branch    = id_branch;
        id_ctrl.mem_read  = id_mem_read;
        id_ctrl.memto_reg = id_memto_reg & id_reg_write;
        id_ctrl.mem_write = id_mem_write;
        id_ctrl.alu_src   = id_alu_src;
        id_ctrl.reg_write = id_reg_write;
        id_ctrl.alu_op    = id_alu_op;
    end

    // A load in EX whose result the ID instruction needs next cycle.
    assign load_use = id_valid && ex_q.ctrl.mem_read && (ex_q.rd != '0) &&
                      ((ex_q.rd == id_rs1) ||
                       (uses_rs2(id_ctrl) && (ex_q.rd == id_rs2)));

    // A taken branch makes the ID instruction wrong-path, so it cannot stall.
    assign flush = branch_taken;
    assign stall = load_use && !flush;

    assign pc_write   = !stall;
    assign ifid_write = !stall;
    assign ifid_flush = flush;

    always_comb begin
        ex_d  = '0;
        mem_d = '0;
        wb_d  = '0;

        if (id_valid && !stall && !flush) begin
            ex_d.ctrl = id_ctrl;
            ex_d.rs1  = id_rs1;
            ex_d.rs2  = id_rs2;
            ex_d.rd   = id_rd;
        end

        if (!flush) begin
            mem_d.ctrl = ex_q.ctrl;
            mem_d.rd   = ex_q.rd;
        end

        // The branch itself sits in MEM when taken and retires normally.
        wb_d = mem_q;
    end

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the pre-edge value of its predecessor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    forwarding_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_forwarding_unit (
        .ex_rs1        (ex_q.rs1),
        .ex_rs2        (ex_q.rs2),
        .mem_reg_write (mem_q.ctrl.reg_write),
        .mem_rd        (mem_q.rd),
        .wb_reg_write  (wb_q.ctrl.reg_write),
        .wb_rd         (wb_q.rd),
        .forward_a     (forward_a),
        .forward_b     (forward_b)
    );

    assign ex_alu_src    = ex_q.ctrl.alu_src;
    assign ex_alu_op     = ex_q.ctrl.alu_op;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;

    assign mem_branch    = mem_q.ctrl.branch;
    assign mem_mem_read  = mem_q.ctrl.mem_read;
    assign mem_mem_write = mem_q.ctrl.mem_write;
    assign mem_rd        = mem_q.rd;

    assign wb_reg_write  = wb_q.ctrl.reg_write;
    assign wb_memto_reg  = wb_q.ctrl.memto_reg;
    assign wb_rd         = wb_q.rd;

    // EX/MEM-only bits of the retired bundle have no consumer in WB.
    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_q.ctrl.branch, wb_q.ctrl.mem_read,
                              wb_q.ctrl.mem_write, wb_q.ctrl.alu_src,
                              wb_q.ctrl.alu_op};

endmodule
